// File: rtl/config_loader_pkg.sv
// Shared constants and types for the configuration frame loader:
// sync word, header field positions and the sequencer state encoding.
package config_loader_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam int DESYNC_BIT = 31;
    localparam int COL_MSB    = 15;
    localparam int COL_LSB    = 8;
    localparam int FRAME_MSB  = 4;
    localparam int FRAME_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        DISCARD
    } state_t;

endpackage

// File: rtl/config_frame_loader.sv
// Locks onto the bitstream sync word, decodes frame headers and steps the
// following row words into the fabric as registered row/frame write strobes.
module config_frame_loader
    import config_loader_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 16,
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 16
) (
    input  logic                            CLK,
    input  logic                            resetn,
    input  logic [31:0]                     WriteData,
    input  logic                            WriteStrobe,
    output logic [FrameBitsPerRow-1:0]      FrameData,
    output logic [$clog2(NumberOfRows)-1:0] RowSelect,
    output logic                            RowStrobe,
    output logic [7:0]                      ColumnSelect,
    output logic [4:0]                      FrameSelect,
    output logic                            FrameStrobe,
    output logic                            Synced,
    output logic                            Error
);

    localparam int RowW = $clog2(NumberOfRows);
    localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);

    state_t                     state, state_nxt;
    logic [RowW-1:0]            row_cnt, row_cnt_nxt;
    logic [FrameBitsPerRow-1:0] frame_data_nxt;
    logic [RowW-1:0]            row_sel_nxt;
    logic                       row_strobe_nxt, frame_strobe_nxt;
    logic [7:0]                 col_sel_nxt;
    logic [4:0]                 frame_sel_nxt;
    logic                       error_nxt;

    logic [7:0] hdr_col;
    logic [4:0] hdr_frame;
    logic       hdr_in_range;

    assign hdr_col      = WriteData[COL_MSB:COL_LSB];
    assign hdr_frame    = WriteData[FRAME_MSB:FRAME_LSB];
    assign hdr_in_range = (32'(hdr_col) < NumColumns) && (32'(hdr_frame) < MaxFramesPerCol);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_nxt        = state;
        row_cnt_nxt      = row_cnt;
        frame_data_nxt   = FrameData;
        row_sel_nxt      = RowSelect;
        row_strobe_nxt   = 1'b0;
        frame_strobe_nxt = 1'b0;
        col_sel_nxt      = ColumnSelect;
        frame_sel_nxt    = FrameSelect;
        error_nxt        = Error;

        if (WriteStrobe) begin
            unique case (state)
                IDLE: begin
                    if (WriteData == SYNC_WORD) begin
                        state_nxt = HEADER;
                        error_nxt = 1'b0;
                    end
                end
                HEADER: begin
                    row_cnt_nxt = '0;
                    if (WriteData[DESYNC_BIT]) begin
                        state_nxt = IDLE;
                    end else if (hdr_in_range) begin
                        col_sel_nxt   = hdr_col;
                        frame_sel_nxt = hdr_frame;
                        state_nxt     = DATA;
                    end else begin
                        error_nxt = 1'b1;
                        state_nxt = DISCARD;
                    end
                end
                DATA: begin
                    // Words here are raw row data, never sync or desync.
                    frame_data_nxt = WriteData[FrameBitsPerRow-1:0];
                    row_sel_nxt    = row_cnt;
                    row_strobe_nxt = 1'b1;
                    if (row_cnt == LastRow) begin
                        frame_strobe_nxt = 1'b1;
                        row_cnt_nxt      = '0;
                        state_nxt        = HEADER;
                    end else begin
                        row_cnt_nxt = row_cnt + RowW'(1);
                    end
                end
                DISCARD: begin
                    if (row_cnt == LastRow) begin
                        row_cnt_nxt = '0;
                        state_nxt   = HEADER;
                    end else begin
                        row_cnt_nxt = row_cnt + RowW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            row_cnt      <= '0;
            FrameData    <= '0;
            RowSelect    <= '0;
            RowStrobe    <= 1'b0;
            ColumnSelect <= '0;
            FrameSelect  <= '0;
            FrameStrobe  <= 1'b0;
            Synced       <= 1'b0;
            Error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            row_cnt      <= row_cnt_nxt;
            FrameData    <= frame_data_nxt;
            RowSelect    <= row_sel_nxt;
            RowStrobe    <= row_strobe_nxt;
            ColumnSelect <= col_sel_nxt;
            FrameSelect  <= frame_sel_nxt;
            FrameStrobe  <= frame_strobe_nxt;
            Synced       <= (state_nxt != IDLE);
            Error        <= error_nxt;
        end
    end

endmodule
